// File: rtl/multi_bcd_conv_if.sv
// Handshake and data bundle for multi_bcd_conv: start/bin_in towards the
// converter, busy/valid/bcd_out/ovf back from it.
interface multi_bcd_conv_if #(
  parameter int CHANNELS = 3,
  parameter int BIN_W    = 6,
  parameter int DIGITS   = 2
);
  logic                         start;
  logic [CHANNELS*BIN_W-1:0]    bin_in;
  logic                         busy;
  logic                         valid;
  logic [CHANNELS*DIGITS*4-1:0] bcd_out;
  logic [CHANNELS-1:0]          ovf;

  modport master (output start, bin_in, input busy, valid, bcd_out, ovf);
  modport slave  (input start, bin_in, output busy, valid, bcd_out, ovf);
endinterface

// File: rtl/multi_bcd_conv.sv
// Multi-channel binary-to-BCD converter (serial double-dabble, one bit per clock).
// Define MULTI_BCD_CONV_BLANK_EN to blank leading zero digits with 4'hF.
module multi_bcd_conv #(
  parameter int CHANNELS = 3,
  parameter int BIN_W    = 6,
  parameter int DIGITS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  multi_bcd_conv_if.slave  bus
);

  // Decimal digits needed to hold 2^bits-1 without loss.
  function automatic int dec_digits(input int bits);
    longint v;
    int     n;
    v = (longint'(1) << bits) - 1;
    n = 1;
    for (int i = 0; i < 6; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int ACC_D = (dec_digits(BIN_W) > DIGITS) ? dec_digits(BIN_W) : DIGITS;
  localparam int ACC_W = ACC_D * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int OUT_W = CHANNELS * DIGITS * 4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_q   [CHANNELS];
  logic [ACC_W-1:0]   acc_q   [CHANNELS];
  logic [ACC_W-1:0]   adj     [CHANNELS];
  logic [ACC_W-1:0]   acc_nxt [CHANNELS];
  logic [OUT_W-1:0]   bcd_q, bcd_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic               valid_q;
  logic               last;
  logic               lead;

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == SHIFT);
    bus.valid   = valid_q;
    bus.bcd_out = bcd_q;
    bus.ovf     = ovf_q;
  end

  // One double-dabble step: add-3 correction, then shift in the next binary MSB.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      adj[ch] = acc_q[ch];
      for (int d = 0; d < ACC_D; d++) begin
        if (acc_q[ch][d*4 +: 4] >= 4'd5)
          adj[ch][d*4 +: 4] = acc_q[ch][d*4 +: 4] + 4'd3;
      end
      acc_nxt[ch] = {adj[ch][ACC_W-2:0], bin_q[ch][BIN_W-1]};
    end
  end

  // Result formatting from the final step: saturate on overflow, optional blanking.
  always_comb begin
    bcd_d = '0;
    ovf_d = '0;
    lead  = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      ovf_d[ch] = ((acc_nxt[ch] >> (DIGITS*4)) != '0);
      for (int d = 0; d < DIGITS; d++)
        bcd_d[(ch*DIGITS+d)*4 +: 4] = ovf_d[ch] ? 4'h9 : acc_nxt[ch][d*4 +: 4];
`ifdef MULTI_BCD_CONV_BLANK_EN
      if (!ovf_d[ch]) begin
        lead = 1'b1;
        for (int d = DIGITS-1; d > 0; d--) begin
          lead = lead && (acc_nxt[ch][d*4 +: 4] == 4'd0);
          if (lead) bcd_d[(ch*DIGITS+d)*4 +: 4] = 4'hF;
        end
      end
`endif
    end
  end

  // NOTE: the shift/accumulator arrays are reset too so an aborted conversion leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        bin_q[ch] <= '0;
        acc_q[ch] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          cnt_q <= CNT_W'(BIN_W);
          for (int ch = 0; ch < CHANNELS; ch++) begin
            bin_q[ch] <= bus.bin_in[ch*BIN_W +: BIN_W];
            acc_q[ch] <= '0;
          end
        end
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
        for (int ch = 0; ch < CHANNELS; ch++) begin
          acc_q[ch] <= acc_nxt[ch];
          bin_q[ch] <= bin_q[ch] << 1;
        end
        if (last) begin
          bcd_q   <= bcd_d;
          ovf_q   <= ovf_d;
          valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
